// File: rtl/diff_scan_unit_pkg.sv
// ============================================================================
// Module : diff_scan_unit_pkg
// Brief  : Shared state encodings, mode constants and ALU default sizes.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package diff_scan_unit_pkg;

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_SCAN = 2'd1,
        DS_DONE = 2'd2
    } ds_state_e;

    localparam logic DIFF_LSB = 1'b0;
    localparam logic DIFF_MSB = 1'b1;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CHUNK = 8;

endpackage

`default_nettype wire

// File: rtl/diff_scan_unit_chunk_prio_enc.sv
// ============================================================================
// Module : chunk_prio_enc
// Brief  : Combinational priority encoder over one chunk, lowest or highest set bit.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module chunk_prio_enc
    import diff_scan_unit_pkg::*;
#(
    parameter int CHUNK = DEF_CHUNK,
    parameter int POS_W = (CHUNK > 1) ? $clog2(CHUNK) : 1
) (
    input  logic [CHUNK-1:0] vec,
    input  logic             dir,
    output logic             any,
    output logic [POS_W-1:0] pos
);

    generate
        if (CHUNK == 1) begin : g_single
            logic unused_dir;
            assign unused_dir = dir;
            assign any = vec[0];
            assign pos = '0;
        end else begin : g_multi
            assign any = |vec;

            // The last matching iteration wins: scan down for lowest, up for highest.
            always_comb begin
                pos = '0;
                if (dir == DIFF_LSB) begin
                    for (int i = CHUNK - 1; i >= 0; i--) begin
                        if (vec[i]) pos = POS_W'(i);
                    end
                end else begin
                    for (int i = 0; i < CHUNK; i++) begin
                        if (vec[i]) pos = POS_W'(i);
                    end
                end
            end
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/diff_scan_unit.sv
// ============================================================================
// Module : diff_scan_unit
// Brief  : Multi-cycle first-differing-bit scanner with valid/ready on both sides.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module diff_scan_unit
    import diff_scan_unit_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK,
    parameter int OUT_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         a,
    input  logic [WIDTH-1:0]         b,
    input  logic                     mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         result,
    output logic                     found,
    output logic [$clog2(WIDTH)-1:0] cycles
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam int NCHK  = WIDTH / CHUNK;
    localparam int CNT_W = (NCHK > 1) ? $clog2(NCHK) : 1;
    localparam int POS_W = (CHUNK > 1) ? $clog2(CHUNK) : 1;

    ds_state_e        state_q,     state_d;
    logic [WIDTH-1:0] diff_q,      diff_d;
    logic             mode_q,      mode_d;
    logic [CNT_W-1:0] chunk_q,     chunk_d;
    logic [IDX_W-1:0] cycles_q,    cycles_d;
    logic [OUT_W-1:0] result_q,    result_d;
    logic             found_q,     found_d;
    logic             out_valid_q, out_valid_d;

    logic [CHUNK-1:0] w_chunk_vec;
    logic             w_any;
    logic [POS_W-1:0] w_pos;
    logic [IDX_W-1:0] w_idx;
    logic [WIDTH-1:0] w_xor;

    assign w_xor       = a ^ b;
    assign w_chunk_vec = diff_q[int'(chunk_q) * CHUNK +: CHUNK];
    assign w_idx       = IDX_W'(int'(chunk_q) * CHUNK + int'(w_pos));

    chunk_prio_enc #(
        .CHUNK (CHUNK),
        .POS_W (POS_W)
    ) u_enc (
        .vec (w_chunk_vec),
        .dir (mode_q),
        .any (w_any),
        .pos (w_pos)
    );

    always_comb begin
        state_d     = state_q;
        diff_d      = diff_q;
        mode_d      = mode_q;
        chunk_d     = chunk_q;
        cycles_d    = cycles_q;
        result_d    = result_q;
        found_d     = found_q;
        out_valid_d = out_valid_q;

        case (state_q)
            DS_IDLE: begin
                if (in_valid) begin
                    diff_d   = w_xor;
                    mode_d   = mode;
                    chunk_d  = (mode == DIFF_MSB) ? CNT_W'(NCHK - 1) : '0;
                    cycles_d = '0;
                    result_d = '0;
                    found_d  = 1'b0;
                    if (w_xor == '0) begin
                        out_valid_d = 1'b1;
                        state_d     = DS_DONE;
                    end else begin
                        state_d     = DS_SCAN;
                    end
                end
            end
            DS_SCAN: begin
                cycles_d = cycles_q + IDX_W'(1);
                // diff is nonzero here, so the final chunk in scan order always hits.
                if (w_any) begin
                    result_d    = OUT_W'(w_idx);
                    found_d     = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = DS_DONE;
                end else if (mode_q == DIFF_MSB) begin
                    chunk_d = chunk_q - CNT_W'(1);
                end else begin
                    chunk_d = chunk_q + CNT_W'(1);
                end
            end
            DS_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = DS_IDLE;
                end
            end
            default: begin
                state_d     = DS_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= DS_IDLE;
            diff_q      <= '0;
            mode_q      <= 1'b0;
            chunk_q     <= '0;
            cycles_q    <= '0;
            result_q    <= '0;
            found_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            diff_q      <= diff_d;
            mode_q      <= mode_d;
            chunk_q     <= chunk_d;
            cycles_q    <= cycles_d;
            result_q    <= result_d;
            found_q     <= found_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == DS_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign found     = found_q;
    assign cycles    = cycles_q;

endmodule

`default_nettype wire
